// File: rtl/spi_asm_pkg.sv
// Shared types and helpers for the SPI word assembler.
package spi_asm_pkg;

  localparam int unsigned WORD_BYTES = 4;

  typedef struct packed {
    logic [31:0] word;
    logic [2:0]  bytes;
    logic        last;
  } asm_entry_t;

  // Move the n low bytes of the pack register to the top of a word, zero-filling below.
  function automatic logic [31:0] left_align(input logic [23:0] acc, input logic [1:0] n);
    logic [31:0] w;
    case (n)
      2'd1:    w = {acc[7:0], 24'h000000};
      2'd2:    w = {acc[15:0], 16'h0000};
      2'd3:    w = {acc, 8'h00};
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/spi_word_assembler_if.sv
// Byte-in / word-out handshake bundle for spi_word_assembler.
interface spi_word_assembler_if;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_frame_end;
  logic [31:0] out_word;
  logic [2:0]  out_bytes;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;
  logic        overrun;
  logic        clear_overrun;

  modport master (
    output in_byte, in_valid, in_frame_end, out_ready, clear_overrun,
    input  out_word, out_bytes, out_last, out_valid, overrun
  );

  modport slave (
    input  in_byte, in_valid, in_frame_end, out_ready, clear_overrun,
    output out_word, out_bytes, out_last, out_valid, overrun
  );
endinterface

// File: rtl/spi_asm_fifo.sv
// Small synchronous FIFO of assembled words with a registered head entry.
module spi_asm_fifo
  import spi_asm_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  asm_entry_t push_data,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output asm_entry_t head
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  asm_entry_t           mem_q [FIFO_DEPTH];
  asm_entry_t           mem_d [FIFO_DEPTH];
  asm_entry_t           head_q, head_d;
  logic       [AW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic       [AW:0]    count_q, count_d;
  logic                 push_ok, pop_ok;

  assign full    = (count_q == (AW + 1)'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign pop_ok  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_ok) begin
      mem_d[wptr_q] = push_data;
      wptr_d        = wptr_q + 1'b1;
    end
    if (pop_ok) begin
      rptr_d = rptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    head_d = (count_d == '0) ? '0 : mem_d[rptr_d];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_q   <= '{default: '0};
      head_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign head = head_q;

endmodule

// File: rtl/spi_word_assembler.sv
// Packs SPI bytes MSB-first into 32-bit words and queues them for the command layer.
// Define SPI_ASM_FLUSH_EN to emit partial words at frame end instead of discarding them.
module spi_word_assembler
  import spi_asm_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input logic                  clock,
  input logic                  reset,
  spi_word_assembler_if.slave  bus
);

  logic [23:0] acc_q, acc_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] shifted;
  logic        overrun_q, overrun_d;
  logic        push, pop, full, empty, drop;
  asm_entry_t  push_entry, head;

  assign shifted = {acc_q[15:0], bus.in_byte};

`ifdef SPI_ASM_FLUSH_EN
  logic [1:0]  flush_n;
  logic [23:0] flush_acc;
  // A coincident byte joins the partial word before it is flushed.
  assign flush_n   = bus.in_valid ? cnt_q + 2'd1 : cnt_q;
  assign flush_acc = bus.in_valid ? shifted : acc_q;
`endif

  always_comb begin
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    push       = 1'b0;
    push_entry = '0;
    if (bus.in_valid && cnt_q == 2'd3) begin
      push             = 1'b1;
      push_entry.word  = {acc_q, bus.in_byte};
      push_entry.bytes = 3'(WORD_BYTES);
      push_entry.last  = bus.in_frame_end;
      acc_d            = '0;
      cnt_d            = '0;
    end else if (bus.in_valid && !bus.in_frame_end) begin
      acc_d = shifted;
      cnt_d = cnt_q + 2'd1;
    end else if (bus.in_frame_end) begin
      acc_d = '0;
      cnt_d = '0;
`ifdef SPI_ASM_FLUSH_EN
      if (flush_n != 2'd0) begin
        push             = 1'b1;
        push_entry.word  = left_align(flush_acc, flush_n);
        push_entry.bytes = {1'b0, flush_n};
        push_entry.last  = 1'b1;
      end
`endif
    end
  end

  assign pop  = !empty && bus.out_ready;
  assign drop = push && full && !pop;

  always_comb begin
    overrun_d = overrun_q;
    if (bus.clear_overrun) overrun_d = 1'b0;
    if (drop)              overrun_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      overrun_q <= overrun_d;
    end
  end

  spi_asm_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .head      (head)
  );

  assign bus.out_word  = head.word;
  assign bus.out_bytes = head.bytes;
  assign bus.out_last  = head.last;
  assign bus.out_valid = !empty;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_spi_word_assembler.sv
// Directed self-checking bench for spi_word_assembler.
module tb_spi_word_assembler;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_pass;

  spi_word_assembler_if bus_if ();

  spi_word_assembler #(
    .FIFO_DEPTH (2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Called at a negedge; returns at the next negedge after the byte was sampled.
  task automatic send_byte(input logic [7:0] b, input logic fe);
    bus_if.in_byte      = b;
    bus_if.in_valid     = 1'b1;
    bus_if.in_frame_end = fe;
    @(negedge clock);
    bus_if.in_valid     = 1'b0;
    bus_if.in_frame_end = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic fe);
    send_byte(w[31:24], 1'b0);
    send_byte(w[23:16], 1'b0);
    send_byte(w[15:8], 1'b0);
    send_byte(w[7:0], fe);
  endtask

  task automatic frame_end();
    bus_if.in_frame_end = 1'b1;
    @(negedge clock);
    bus_if.in_frame_end = 1'b0;
  endtask

  task automatic pulse_clear();
    bus_if.clear_overrun = 1'b1;
    @(negedge clock);
    bus_if.clear_overrun = 1'b0;
  endtask

  initial begin
    n_checks             = 0;
    n_pass               = 0;
    reset                = 1'b0;
    bus_if.in_byte       = 8'h00;
    bus_if.in_valid      = 1'b0;
    bus_if.in_frame_end  = 1'b0;
    bus_if.out_ready     = 1'b0;
    bus_if.clear_overrun = 1'b0;

    repeat (2) @(negedge clock);
    check("rst_valid", 32'(bus_if.out_valid), 32'd0);
    check("rst_word", bus_if.out_word, 32'h0);
    check("rst_bytes", 32'(bus_if.out_bytes), 32'd0);
    check("rst_last", 32'(bus_if.out_last), 32'd0);
    check("rst_overrun", 32'(bus_if.overrun), 32'd0);
    reset = 1'b1;
    @(negedge clock);

    // Basic word
    bus_if.out_ready = 1'b1;
    send_byte(8'hDE, 1'b0);
    send_byte(8'hAD, 1'b0);
    send_byte(8'hBE, 1'b0);
    check("w1_not_yet", 32'(bus_if.out_valid), 32'd0);
    send_byte(8'hEF, 1'b0);
    check("w1_valid", 32'(bus_if.out_valid), 32'd1);
    check("w1_word", bus_if.out_word, 32'hDEADBEEF);
    check("w1_bytes", 32'(bus_if.out_bytes), 32'd4);
    check("w1_last", 32'(bus_if.out_last), 32'd0);
    @(negedge clock);
    check("w1_popped", 32'(bus_if.out_valid), 32'd0);

    // 4th byte coincident with frame end
    send_word(32'h11223344, 1'b1);
    check("w2_valid", 32'(bus_if.out_valid), 32'd1);
    check("w2_word", bus_if.out_word, 32'h11223344);
    check("w2_last", 32'(bus_if.out_last), 32'd1);
    @(negedge clock);

    // Partial frame
    send_byte(8'hA5, 1'b0);
    send_byte(8'h5A, 1'b0);
    frame_end();
`ifdef SPI_ASM_FLUSH_EN
    check("flush_valid", 32'(bus_if.out_valid), 32'd1);
    check("flush_word", bus_if.out_word, 32'hA55A0000);
    check("flush_bytes", 32'(bus_if.out_bytes), 32'd2);
    check("flush_last", 32'(bus_if.out_last), 32'd1);
`else
    check("noflush_valid", 32'(bus_if.out_valid), 32'd0);
`endif
    @(negedge clock);
    check("flush_drained", 32'(bus_if.out_valid), 32'd0);
    send_word(32'hC1C2C3C4, 1'b0);
    check("post_fe_word", bus_if.out_word, 32'hC1C2C3C4);
    @(negedge clock);

    // Overrun with consumer stalled
    bus_if.out_ready = 1'b0;
    send_word(32'h0A0B0C0D, 1'b0);
    check("ov_head1", bus_if.out_word, 32'h0A0B0C0D);
    send_word(32'h1A1B1C1D, 1'b0);
    check("ov_full_no_flag", 32'(bus_if.overrun), 32'd0);
    send_word(32'h2A2B2C2D, 1'b0);
    check("ov_flag", 32'(bus_if.overrun), 32'd1);
    check("ov_head_hold", bus_if.out_word, 32'h0A0B0C0D);
    bus_if.out_ready = 1'b1;
    @(negedge clock);
    check("ov_second_valid", 32'(bus_if.out_valid), 32'd1);
    check("ov_second_word", bus_if.out_word, 32'h1A1B1C1D);
    @(negedge clock);
    check("ov_empty", 32'(bus_if.out_valid), 32'd0);
    bus_if.out_ready = 1'b0;

    // Clear, then clear coincident with a new drop
    pulse_clear();
    check("clr_overrun", 32'(bus_if.overrun), 32'd0);
    send_word(32'h31323334, 1'b0);
    send_word(32'h41424344, 1'b0);
    send_byte(8'h51, 1'b0);
    send_byte(8'h52, 1'b0);
    send_byte(8'h53, 1'b0);
    bus_if.clear_overrun = 1'b1;
    send_byte(8'h54, 1'b0);
    bus_if.clear_overrun = 1'b0;
    check("set_wins", 32'(bus_if.overrun), 32'd1);
    check("set_wins_head", bus_if.out_word, 32'h31323334);
    pulse_clear();
    check("clr_again", 32'(bus_if.overrun), 32'd0);

    // Full FIFO with pop and push in the same cycle
    send_byte(8'h61, 1'b0);
    send_byte(8'h62, 1'b0);
    send_byte(8'h63, 1'b0);
    bus_if.out_ready = 1'b1;
    send_byte(8'h64, 1'b0);
    bus_if.out_ready = 1'b0;
    check("pp_no_overrun", 32'(bus_if.overrun), 32'd0);
    check("pp_head", bus_if.out_word, 32'h41424344);
    bus_if.out_ready = 1'b1;
    @(negedge clock);
    check("pp_pushed_word", bus_if.out_word, 32'h61626364);
    @(negedge clock);
    check("pp_empty", 32'(bus_if.out_valid), 32'd0);
    bus_if.out_ready = 1'b0;

    // Asynchronous reset mid-word with a queued entry
    send_word(32'h99AABBCC, 1'b0);
    send_byte(8'h77, 1'b0);
    send_byte(8'h88, 1'b0);
    #1 reset = 1'b0;
    #1;
    check("arst_valid", 32'(bus_if.out_valid), 32'd0);
    check("arst_word", bus_if.out_word, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    bus_if.out_ready = 1'b1;
    send_word(32'h01020304, 1'b0);
    check("arst_after_valid", 32'(bus_if.out_valid), 32'd1);
    check("arst_after_word", bus_if.out_word, 32'h01020304);
    check("arst_after_bytes", 32'(bus_if.out_bytes), 32'd4);
    @(negedge clock);
    check("arst_after_empty", 32'(bus_if.out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_word_assembler.md
# spi_word_assembler

Downstream consumer of the SPI slave byte stream. Packs received bytes MSB-first into 32-bit words and buffers them in a 2-entry FIFO. Words are presented to the register/command layer over a valid/ready handshake. Handles frame (SS) boundaries and reports FIFO overrun with a sticky flag.

## Interface
- `FIFO_DEPTH`, default 2: output FIFO entries; power of two, ≥2.
- `clock`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_byte`  in  8  byte from the SPI slave; sampled only when `in_valid`=1.
- `in_valid`  in  1  one-cycle strobe: byte complete.
- `in_frame_end`  in  1  one-cycle strobe: SS deasserted, already synchronised upstream.
- `out_word`  out  32  assembled word; first received byte in [31:24].
- `out_bytes`  out  3  valid bytes in `out_word` (1..4).
- `out_last`  out  1  word closes a frame.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  consumer accepts the head when `out_valid`&&`out_ready`.
- `overrun`  out  1  sticky: a word was dropped because the FIFO was full.
- `clear_overrun`  in  1  clears `overrun` on the next edge.

## Operation
- Pack register `acc[23:0]` and byte count `cnt[1:0]` (0..3).
- On `in_valid` with `cnt`<3: `acc` ← {`acc[15:0]`, `in_byte`}; `cnt`++.
- On `in_valid` with `cnt`==3: push {`acc`, `in_byte`}, `bytes`=4, `last`=`in_frame_end`. `cnt` ← 0.
- `in_frame_end` without `in_valid`:
  - `cnt`==0: no push.
  - `cnt`>0: handled per Configuration.
  - In both cases `cnt` ← 0 and `acc` ← 0.
- Simultaneous `in_valid` and `in_frame_end`: the byte is processed first, then the frame end. With `cnt`==3 this gives a single push with `last`=1. With `cnt`<3 it gives a flush containing `cnt`+1 bytes.
- A frame whose length is an exact multiple of 4, with SS rising after the last byte, yields a final word with `out_last`=0. This is intended; the consumer uses its own frame tracking in that case.
- FIFO full at a push, with no pop in the same cycle: the word is dropped, `overrun` ← 1, and pack state still resets.
- FIFO full at a push with a pop in the same cycle: the push succeeds.
- `overrun` set and `clear_overrun` in the same cycle: the set wins.

## Timing
- Reset values:
  - `out_valid`=0, `out_word`=0, `out_bytes`=0, `out_last`=0, `overrun`=0.
  - `cnt`=0, `acc`=0, FIFO empty.
- Latency: the push edge is cycle N. With the FIFO empty, `out_valid`=1 and the data are stable at N+1.
- `out_word`, `out_bytes` and `out_last` hold while `out_valid`=1 and `out_ready`=0.
- `out_valid` never drops without a handshake.
- Pop and push in the same cycle are allowed at any fill level, including empty: the pushed data appear on the following cycle.
- Throughput: 1 word/cycle out. Input bytes arrive at most every cycle.
- Reset asserted mid-word or with the FIFO non-empty discards all contents immediately and asynchronously.

## Configuration
- `SPI_ASM_FLUSH_EN` defined: a frame end with `cnt`>0 pushes a partial word.
  - Bytes are left-aligned and the unused low bytes are zero.
  - `out_bytes`=`cnt` (after any coincident byte), `out_last`=1.
  - The FIFO-full rule above applies.
- `SPI_ASM_FLUSH_EN` undefined: partial words are silently discarded.
  - `out_bytes` is constant 4.
  - `out_last` is asserted only via the coincident 4th-byte case.

## Structure
- Package `spi_asm_pkg` holds:
  - Constant `WORD_BYTES`=4.
  - Typedef `asm_entry_t` {`word`[31:0], `bytes`[2:0], `last`}.
- Sub-module `spi_asm_fifo`: synchronous FIFO of `asm_entry_t`, depth `FIFO_DEPTH`.
  - Push/pop/full/empty ports.
  - Head output registered.
- The top level contains the pack logic and the overrun flag only.

## Test plan
- Byte stream 0xDE, 0xAD, 0xBE, 0xEF with `out_ready`=1 → one word 0xDEADBEEF, `out_bytes`=4, `out_last`=0, `out_valid` one cycle after the 4th strobe.
- Bytes 0x11, 0x22, 0x33, then 0x44 coincident with `in_frame_end` → 0x11223344, `out_last`=1.
- Flush enabled: bytes 0xA5, 0x5A, then `in_frame_end` → 0xA55A0000, `out_bytes`=2, `out_last`=1. Flush disabled: same stimulus → no word, `out_valid` stays 0.
- `out_ready`=0, three full words sent → first two held in order, third dropped, `overrun`=1. Then `out_ready`=1 → two handshakes, FIFO empty.
- `overrun`=1, `clear_overrun` pulsed → 0. Pulse coincident with a new drop → remains 1.
- Reset asserted after 2 bytes, then released, then 4 bytes 0x01..0x04 → single word 0x01020304, with no stale bytes.
